// File: rtl/microondas_pkg.sv
// Shared definitions for the microwave oven controller: state encoding and
// default timing constants.
package microondas_pkg;

    typedef enum logic [2:0] {
        st_idle    = 3'd0,
        st_setting = 3'd1,
        st_cooking = 3'd2,
        st_paused  = 3'd3,
        st_done    = 3'd4
    } estado_t;

    localparam int TICK_DIV_DEF  = 50000000;
    localparam int DONE_SECS_DEF = 3;

endpackage

// File: rtl/microondas_divisor_tick.sv
// One-second prescaler: counts 0..TICK_DIV-1 while run is high, holds otherwise,
// and flags the last count as tick.
module divisor_tick
    import microondas_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic sync_clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (sync_clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    // Gated by run so a count parked at LAST while paused does not tick.
    assign tick = run & (cnt == LAST);

endmodule

// File: rtl/microondas_controle.sv
// Microwave oven controller: button edge detection, cooking FSM, timer
// load/clear/enable strobes and registered Moore outputs.
module microondas_controle
    import microondas_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int DONE_SECS = DONE_SECS_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       key_valid,
    input  logic       timer_zero,
    output logic       timer_loadn,
    output logic       timer_clrn,
    output logic       timer_enable,
    output logic       mag_on,
    output logic       lamp_on,
    output logic       buzzer,
    output logic [2:0] state
);

    localparam int SW = $clog2(DONE_SECS + 1);
    localparam logic [SW-1:0] SECS_LAST = SW'(DONE_SECS - 1);

    estado_t       st_q, st_d;
    logic          start_q, stop_q;
    logic          start_rise, stop_rise;
    logic          run, sync_clr, tick;
    logic [SW-1:0] secs_q;
    logic          load_req, clr_req;

    assign start_rise = start & ~start_q;
    assign stop_rise  = stop & ~stop_q;

    // Branch order inside each state encodes the event priority:
    // stop, door open, timer_zero, start, keypad.
    always_comb begin
        st_d     = st_q;
        load_req = 1'b0;
        clr_req  = 1'b0;
        case (st_q)
            st_idle, st_setting: begin
                if (stop_rise) begin
                    st_d    = st_idle;
                    clr_req = 1'b1;
                end else if (start_rise && door_closed && !timer_zero) begin
                    st_d = st_cooking;
                end else if (key_valid) begin
                    st_d     = st_setting;
                    load_req = 1'b1;
                end
            end
            st_cooking: begin
                if (stop_rise || !door_closed) begin
                    st_d = st_paused;
                end else if (timer_zero) begin
                    st_d = st_done;
                end
            end
            st_paused: begin
                if (stop_rise) begin
                    st_d    = st_idle;
                    clr_req = 1'b1;
                end else if (start_rise && door_closed) begin
                    st_d = st_cooking;
                end
            end
            st_done: begin
                if (stop_rise || !door_closed) begin
                    st_d = st_idle;
                end else if (tick && (secs_q == SECS_LAST)) begin
                    st_d = st_idle;
                end
            end
            default: st_d = st_idle;
        endcase
    end

    // Resuming from PAUSED keeps the prescaler phase; a fresh cook or the
    // buzzer phase starts a whole second from zero.
    assign run      = (st_q == st_cooking) || (st_q == st_done);
    assign sync_clr = ((st_d == st_cooking) && ((st_q == st_idle) || (st_q == st_setting)))
                    || ((st_d == st_done) && (st_q != st_done));

    divisor_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_divisor_tick (
        .clock    (clock),
        .reset    (reset),
        .run      (run),
        .sync_clr (sync_clr),
        .tick     (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_q    <= st_idle;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            secs_q  <= '0;
        end else begin
            st_q    <= st_d;
            start_q <= start;
            stop_q  <= stop;
            if ((st_q == st_done) && (st_d == st_done)) begin
                secs_q <= secs_q + SW'(tick);
            end else begin
                secs_q <= '0;
            end
        end
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_loadn  <= 1'b1;
            timer_clrn   <= 1'b0;
            timer_enable <= 1'b0;
            mag_on       <= 1'b0;
            lamp_on      <= 1'b0;
            buzzer       <= 1'b0;
        end else begin
            timer_loadn  <= ~(load_req & ~clr_req);
            timer_clrn   <= ~clr_req;
            timer_enable <= tick & (st_q == st_cooking) & ~timer_zero & (st_d == st_cooking);
            mag_on       <= (st_d == st_cooking);
            lamp_on      <= (st_d == st_cooking) | ~door_closed;
            buzzer       <= (st_d == st_done);
        end
    end

    assign state = st_q;

endmodule
